// File: rtl/hc_sr04_multi_ranger.sv
// Round-robin HC-SR04 ultrasonic ranger: triggers N_CH sensors in turn.
// Each echo width is converted to centimetres, with per-channel timeout and alarm flags.
module hc_sr04_multi_ranger #(
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TRIG_CYC    = 120,
  parameter int unsigned TIMEOUT_CYC = 360_000,
  parameter int unsigned PERIOD_CYC  = 600_000,
  parameter int unsigned ALARM_CM    = 5,
  parameter int unsigned HYST_CM     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_CH-1:0]      echo,
  output logic [N_CH-1:0]      trig,
  output logic [N_CH*16-1:0]   dist_cm,
  output logic                 valid,
  output logic [2:0]           ch_idx,
  output logic [N_CH-1:0]      timeout,
  output logic [N_CH-1:0]      alarm,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, COUNT, DONE, GAP} state_t;

  state_t                r_state, w_next;
  logic [N_CH-1:0]       r_sync1, r_sync2, r_echo_d;
  logic [2:0]            r_ch;
  logic [31:0]           r_pcnt, r_tcnt, r_wcnt;
  logic [23:0]           r_raw;
  logic [N_CH*16-1:0]    r_dist;
  logic [N_CH-1:0]       r_timeout, r_alarm;
  logic [N_CH-1:0]       w_sel;
  logic                  w_echo, w_rise, w_tmo;
  logic [15:0]           w_dist;

  function automatic logic [15:0] raw_to_cm(input logic [23:0] raw);
    logic [47:0] num, den, q;
    num = 48'(raw) * 48'd34300;
    den = 48'(CLK_HZ) * 48'd2;
    q   = num / den;
    if (q > 48'h0000_0000_FFFF) return 16'hFFFF;
    return q[15:0];
  endfunction

  function automatic logic next_alarm(input logic [15:0] d, input logic to, input logic prev);
    if (to) return 1'b0;
    if (d <= 16'(ALARM_CM)) return 1'b1;
    if (d > 16'(ALARM_CM + HYST_CM)) return 1'b0;
    return prev;
  endfunction

  assign w_sel  = N_CH'(1) << r_ch;
  assign w_echo = |(r_sync2 & w_sel);
  assign w_rise = w_echo & ~(|(r_echo_d & w_sel));
  assign w_tmo  = (r_wcnt >= TIMEOUT_CYC - 1);
  assign w_dist = w_tmo ? 16'hFFFF : raw_to_cm(r_raw);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (en) w_next = TRIG;
      TRIG:      if (r_tcnt >= TRIG_CYC - 1) w_next = WAIT_ECHO;
      WAIT_ECHO: if (w_tmo) w_next = DONE;
                 else if (w_rise) w_next = COUNT;
      COUNT:     if (w_tmo || !w_echo) w_next = DONE;
      DONE:      w_next = GAP;
      // One IDLE cycle follows GAP, so exit two short of the period
      GAP:       if (r_pcnt >= PERIOD_CYC - 2) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_echo_d  <= '0;
      r_ch      <= '0;
      r_pcnt    <= '0;
      r_tcnt    <= '0;
      r_wcnt    <= '0;
      r_raw     <= '0;
      r_dist    <= '0;
      r_timeout <= '0;
      r_alarm   <= '0;
    end else begin
      r_state  <= w_next;
      r_sync1  <= echo;
      r_sync2  <= r_sync1;
      r_echo_d <= r_sync2;
      r_pcnt   <= (r_state == IDLE && w_next == TRIG) ? 32'd0 : r_pcnt + 32'd1;
      r_tcnt   <= (r_state == TRIG) ? r_tcnt + 32'd1 : 32'd0;
      r_wcnt   <= (r_state == WAIT_ECHO || r_state == COUNT) ? r_wcnt + 32'd1 : 32'd0;
      // The edge-detect cycle is itself an echo-high cycle, so COUNT starts at 1
      if (r_state == WAIT_ECHO)
        r_raw <= 24'd1;
      else if (r_state == COUNT && w_echo)
        r_raw <= r_raw + 24'd1;
      // Results land on DONE entry so they are visible while valid is high
      if (w_next == DONE && r_state != DONE) begin
        for (int k = 0; k < N_CH; k++) begin
          if (w_sel[k]) begin
            r_dist[16*k +: 16] <= w_dist;
            r_timeout[k]       <= w_tmo;
            r_alarm[k]         <= next_alarm(w_dist, w_tmo, r_alarm[k]);
          end
        end
      end
      if (r_state == GAP && w_next == IDLE)
        r_ch <= (r_ch == 3'(N_CH - 1)) ? 3'd0 : r_ch + 3'd1;
    end
  end

  assign trig    = (r_state == TRIG) ? w_sel : '0;
  assign valid   = (r_state == DONE);
  assign busy    = (r_state != IDLE);
  assign ch_idx  = r_ch;
  assign dist_cm = r_dist;
  assign timeout = r_timeout;
  assign alarm   = r_alarm;

endmodule

// File: doc/hc_sr04_multi_ranger.md
HC_SR04_MULTI_RANGER -- requirements
Module: hc_sr04_multi_ranger

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4, number of sensor channels (1..8).
REQ-003 SHALL have parameter TRIG_CYC, default 120, trigger pulse width in clk cycles (~10 µs).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 360_000, max cycles from WAIT_ECHO entry to echo fall (~30 ms).
REQ-005 SHALL have parameter PERIOD_CYC, default 600_000, cycles from one trigger start to the next (~50 ms).
REQ-006 SHALL have parameter ALARM_CM, default 5, alarm set threshold in cm.
REQ-007 SHALL have parameter HYST_CM, default 2, alarm clear hysteresis in cm.
REQ-008 SHALL have port clk, input, 1 bit, single system clock.
REQ-009 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-010 SHALL have port en, input, 1 bit, enables round-robin scanning.
REQ-011 SHALL have port echo, input, N_CH bits, raw ECHO pins, asynchronous to clk.
REQ-012 SHALL have port trig, output, N_CH bits, TRIG pins, at most one bit high at a time.
REQ-013 SHALL have port dist_cm, output, N_CH*16 bits, last distance per channel, channel k at bits [16k+15:16k].
REQ-014 SHALL have port valid, output, 1 bit, one-cycle pulse when a result is written.
REQ-015 SHALL have port ch_idx, output, 3 bits, channel of current measurement / of result when valid=1.
REQ-016 SHALL have port timeout, output, N_CH bits, per-channel flag, 1 = last measurement timed out.
REQ-017 SHALL have port alarm, output, N_CH bits, per-channel proximity alarm with hysteresis.
REQ-018 SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-019 SHALL pass each echo bit through a 2-flop synchroniser; all echo decisions SHALL use the synchronised value.
REQ-020 SHALL implement states IDLE, TRIG, WAIT_ECHO, COUNT, DONE, GAP.
REQ-021 IDLE->TRIG when en=1; the period counter SHALL be cleared on TRIG entry.
REQ-022 TRIG SHALL drive trig[ch_idx]=1 for exactly TRIG_CYC cycles, then go to WAIT_ECHO.
REQ-023 WAIT_ECHO->COUNT on a synchronised 0->1 edge of echo[ch_idx]; a level already high on entry SHALL NOT start COUNT.
REQ-024 COUNT SHALL increment a 24-bit raw counter (cleared on COUNT entry) each cycle echo is high; on echo low -> DONE.
REQ-025 If WAIT_ECHO+COUNT cycles reach TIMEOUT_CYC -> DONE, marked timed out.
REQ-026 DONE (1 cycle) SHALL write dist_cm[ch_idx], timeout[ch_idx] and alarm[ch_idx], pulse valid, then -> GAP.
REQ-027 Distance SHALL be floor(raw*34300/(2*CLK_HZ)), computed at ≥40-bit width, saturated to 16'hFFFF.
REQ-028 A timed-out result SHALL write 16'hFFFF and timeout=1; a normal result SHALL write timeout=0.
REQ-029 alarm SHALL set when written dist ≤ ALARM_CM, clear when dist > ALARM_CM+HYST_CM, else hold; timeout SHALL clear alarm.
REQ-030 GAP SHALL wait until the period counter reaches PERIOD_CYC, then advance ch_idx (N_CH-1 wraps to 0) and -> IDLE.
REQ-031 en deasserted mid-measurement SHALL NOT abort; the measurement completes through DONE, and GAP exits to IDLE, which holds while en=0.
REQ-032 Channels not being measured SHALL keep their dist_cm, timeout and alarm unchanged.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, ch_idx=0, trig=0, valid=0, busy=0, dist_cm=0, timeout=0, alarm=0, and clear all counters and synchronisers.
REQ-034 rst asserted mid-TRIG SHALL drop trig in the same cycle, without waiting for a clock edge.

Verification
REQ-035 With defaults, ch0 echo high for 7000 cycles after trig -> dist_cm[15:0]=10, valid pulses once with ch_idx=0, alarm[0]=0.
REQ-036 ch1 echo 1400 cycles -> dist 2, alarm[1]=1; next ch1 echo 4200 cycles (6 cm) -> alarm[1]=1 held; next 5600 cycles (8 cm) -> alarm[1]=0.
REQ-037 No echo on ch2 -> valid exactly TIMEOUT_CYC cycles after WAIT_ECHO entry, dist 16'hFFFF, timeout[2]=1, alarm[2]=0.
REQ-038 en=1 continuously -> trig pulses of 120 cycles visit ch 0,1,2,3,0 with trig rising edges exactly 600_000 cycles apart.
REQ-039 rst pulsed during COUNT on ch3 -> trig=0, busy=0 and all outputs zero, with no valid; after release scanning restarts at ch0.
